// File: rtl/sha256_round_sequencer.sv
// SHA-256 command-side sequencer: loads a 512-bit block, runs the message schedule
// and round control for an external round datapath, chains H and streams the digest.
module sha256_round_sequencer (
   input  logic        clk,
   input  logic        rst,
   input  logic        msg_valid,
   output logic        msg_ready,
   input  logic [31:0] msg_word,
   input  logic        msg_first,
   input  logic        msg_last,
   output logic        dig_valid,
   input  logic        dig_ready,
   output logic [31:0] dig_word,
   output logic [31:0] core_in_var,
   output logic [31:0] core_w,
   output logic [5:0]  core_k_num,
   output logic [3:0]  core_mem_in_addr,
   output logic [3:0]  core_mem_out_addr,
   output logic        core_en_mem_out,
   input  logic [31:0] core_out_var
);

   localparam int unsigned WORD_W = 32;
   localparam int unsigned WIN_N  = 16;
   localparam int unsigned H_N    = 8;
   localparam int unsigned CNT_W  = 6;
   localparam int unsigned ADDR_W = 4;
   localparam logic [ADDR_W-1:0] ADDR_FB = ADDR_W'(15);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_INIT, S_ROUND, S_READ, S_OUT} state_t;

   function automatic logic [WORD_W-1:0] iv(input logic [2:0] i);
      case (i)
         3'd0:    return 32'h6a09e667;
         3'd1:    return 32'hbb67ae85;
         3'd2:    return 32'h3c6ef372;
         3'd3:    return 32'ha54ff53a;
         3'd4:    return 32'h510e527f;
         3'd5:    return 32'h9b05688c;
         3'd6:    return 32'h1f83d9ab;
         default: return 32'h5be0cd19;
      endcase
   endfunction

   function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
      return (x >> n) | (x << (WORD_W - n));
   endfunction

   function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [WORD_W-1:0]   w_q [WIN_N];
   logic [WORD_W-1:0]   w_d [WIN_N];
   logic [WORD_W-1:0]   h_q [H_N];
   logic [WORD_W-1:0]   h_d [H_N];
   logic                last_q, last_d;
   logic                msg_ready_q, msg_ready_d;
   logic                dig_valid_q, dig_valid_d;
   logic [WORD_W-1:0]   dig_word_q, dig_word_d;
   logic [WORD_W-1:0]   in_var_q, in_var_d;
   logic [WORD_W-1:0]   core_w_q, core_w_d;
   logic [CNT_W-1:0]    k_q, k_d;
   logic [ADDR_W-1:0]   in_addr_q, in_addr_d;
   logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
   logic                en_q, en_d;
   logic                xfer;
   logic [WORD_W-1:0]   w_new;

   assign xfer  = msg_valid && msg_ready_q;
   // Window holds W_t..W_t+15 with W_t at slot 0, so the appended word is W_t+16
   assign w_new = sig1(w_q[14]) + w_q[9] + sig0(w_q[1]) + w_q[0];

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      w_d         = w_q;
      h_d         = h_q;
      last_d      = last_q;
      dig_valid_d = dig_valid_q;
      dig_word_d  = dig_word_q;
      in_var_d    = in_var_q;
      core_w_d    = core_w_q;
      k_d         = k_q;
      in_addr_d   = ADDR_FB;
      out_addr_d  = '0;
      en_d        = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (xfer) begin
               w_d[0] = msg_word;
               last_d = msg_last;
               if (msg_first) begin
                  for (int i = 0; i < H_N; i++) h_d[i] = iv(3'(i));
               end
               cnt_d   = CNT_W'(1);
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            if (xfer) begin
               w_d[cnt_q[3:0]] = msg_word;
               if (cnt_q == CNT_W'(15)) begin
                  cnt_d     = '0;
                  state_d   = S_INIT;
                  in_addr_d = '0;
                  in_var_d  = h_q[0];
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         S_INIT: begin
            if (cnt_q == CNT_W'(7)) begin
               cnt_d    = '0;
               state_d  = S_ROUND;
               en_d     = 1'b1;
               k_d      = '0;
               core_w_d = w_q[0];
            end else begin
               cnt_d     = cnt_q + CNT_W'(1);
               in_addr_d = ADDR_W'(cnt_q + CNT_W'(1));
               in_var_d  = h_q[3'(cnt_q + CNT_W'(1))];
            end
         end
         S_ROUND: begin
            for (int i = 0; i < WIN_N - 1; i++) w_d[i] = w_q[i+1];
            w_d[WIN_N-1] = w_new;
            if (cnt_q == CNT_W'(63)) begin
               cnt_d   = '0;
               state_d = S_READ;
            end else begin
               cnt_d    = cnt_q + CNT_W'(1);
               en_d     = 1'b1;
               k_d      = cnt_q + CNT_W'(1);
               core_w_d = w_q[1];
            end
         end
         S_READ: begin
            h_d[cnt_q[2:0]] = h_q[cnt_q[2:0]] + core_out_var;
            if (cnt_q == CNT_W'(7)) begin
               cnt_d   = '0;
               state_d = last_q ? S_OUT : S_IDLE;
            end else begin
               cnt_d      = cnt_q + CNT_W'(1);
               out_addr_d = ADDR_W'(cnt_q + CNT_W'(1));
            end
         end
         S_OUT: begin
            // First OUT cycle only presents H0; afterwards advance per accepted word
            if (!dig_valid_q) begin
               dig_valid_d = 1'b1;
               dig_word_d  = h_q[cnt_q[2:0]];
            end else if (dig_ready) begin
               if (cnt_q == CNT_W'(7)) begin
                  cnt_d       = '0;
                  dig_valid_d = 1'b0;
                  state_d     = S_IDLE;
               end else begin
                  cnt_d      = cnt_q + CNT_W'(1);
                  dig_word_d = h_q[3'(cnt_q + CNT_W'(1))];
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      msg_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         for (int i = 0; i < WIN_N; i++) w_q[i] <= '0;
         for (int i = 0; i < H_N; i++) h_q[i] <= iv(3'(i));
         last_q      <= 1'b0;
         msg_ready_q <= 1'b1;
         dig_valid_q <= 1'b0;
         dig_word_q  <= '0;
         in_var_q    <= '0;
         core_w_q    <= '0;
         k_q         <= '0;
         in_addr_q   <= ADDR_FB;
         out_addr_q  <= '0;
         en_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         w_q         <= w_d;
         h_q         <= h_d;
         last_q      <= last_d;
         msg_ready_q <= msg_ready_d;
         dig_valid_q <= dig_valid_d;
         dig_word_q  <= dig_word_d;
         in_var_q    <= in_var_d;
         core_w_q    <= core_w_d;
         k_q         <= k_d;
         in_addr_q   <= in_addr_d;
         out_addr_q  <= out_addr_d;
         en_q        <= en_d;
      end
   end

   assign msg_ready         = msg_ready_q;
   assign dig_valid         = dig_valid_q;
   assign dig_word          = dig_word_q;
   assign core_in_var       = in_var_q;
   assign core_w            = core_w_q;
   assign core_k_num        = k_q;
   assign core_mem_in_addr  = in_addr_q;
   assign core_mem_out_addr = out_addr_q;
   assign core_en_mem_out   = en_q;

endmodule
